// File: rtl/assoc_wb_cache_if.sv
// Bus bundle for assoc_wb_cache: CPU word port, line-wide memory port and
// statistics. The cache is the slave; the CPU/memory side is the master.
//
// Handshake semantics:
//   CPU side: a request is accepted on a rising edge where cpu_req=1 and
//   cpu_ready=1. A request while cpu_ready=0 is dropped, not queued.
//   cpu_rvalid is a one-cycle pulse qualifying cpu_rdata.
//   Memory side: mem_rd is a one-cycle refill pulse. The line returns later
//   on a one-cycle mem_rvalid. mem_wr, mem_addr and mem_wdata stay stable
//   until the edge where mem_wack=1.
interface assoc_wb_cache_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int LA_W   = 28
);
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              mem_rd;
  logic              mem_wr;
  logic [LA_W-1:0]   mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_wack;
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata, mem_rdata, mem_rvalid, mem_wack,
    output cpu_ready, cpu_rdata, cpu_rvalid, mem_rd, mem_wr, mem_addr, mem_wdata,
           stat_hits, stat_misses
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata, mem_rdata, mem_rvalid, mem_wack,
    input  cpu_ready, cpu_rdata, cpu_rvalid, mem_rd, mem_wr, mem_addr, mem_wdata,
           stat_hits, stat_misses
  );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate cache with true-LRU
// replacement, dirty-line writeback, miss refill and hit/miss counters.
module assoc_wb_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  assoc_wb_cache_if.slave   bus,
  output logic [2:0]        dbg_state_o
);
  localparam int OFF    = $clog2(LINE_WORDS) + 2;
  localparam int IDX    = $clog2(SETS);
  localparam int TAG    = ADDR_W - OFF - IDX;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam int LA_W   = ADDR_W - OFF;
  localparam int AW     = $clog2(WAYS);
  localparam int WW     = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_COMPARE     = 3'd1,
    S_WRITEBACK   = 3'd2,
    S_REFILL_REQ  = 3'd3,
    S_REFILL_WAIT = 3'd4
  } state_t;

  state_t             state_q;
  logic               ready_q, mem_rd_q, mem_wr_q, first_q, wren_q;
  logic [LA_W-1:0]    mem_addr_q;
  logic [LINE_W-1:0]  mem_wdata_q;
  logic [31:0]        hits_q, misses_q, wdata_q;
  logic [ADDR_W-3:0]  la_q;       // registered word address
  logic [AW-1:0]      victim_q;

  logic [TAG-1:0]     tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]  data_q  [WAYS][SETS];
  logic [AW-1:0]      age_q   [WAYS][SETS];
  logic [WAYS-1:0]    valid_q [SETS];
  logic [WAYS-1:0]    dirty_q [SETS];

  logic [WW-1:0]      word_sel;
  logic [IDX-1:0]     idx;
  logic [TAG-1:0]     tag;
  logic [LA_W-1:0]    line_addr;
  logic               hit, vic_found, lru_en;
  logic [AW-1:0]      hit_way, vic_way, upd_way, upd_age;
  logic [31:0]        hit_word;
  logic               unused_addr_bits;

  assign word_sel  = la_q[WW-1:0];
  assign idx       = la_q[WW+IDX-1:WW];
  assign tag       = la_q[ADDR_W-3:WW+IDX];
  assign line_addr = la_q[ADDR_W-3:WW];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Tag lookup for the registered address and victim choice on a miss.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    vic_found = 1'b0;
    vic_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
      if (!vic_found && !valid_q[idx][w]) begin
        vic_found = 1'b1;
        vic_way   = AW'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[w][idx] == AW'(WAYS - 1)) vic_way = AW'(w);
      end
    end
  end

  // LRU touch source: the hit way in COMPARE, the victim way on install.
  always_comb begin
    upd_way = (state_q == S_COMPARE) ? hit_way : victim_q;
    upd_age = age_q[upd_way][idx];
    lru_en  = ((state_q == S_COMPARE) && hit) ||
              ((state_q == S_REFILL_WAIT) && bus.mem_rvalid);
  end

  assign hit_word        = data_q[hit_way][idx][{word_sel, 5'b0} +: 32];
  assign bus.cpu_rvalid  = (state_q == S_COMPARE) && hit && !wren_q;
  assign bus.cpu_rdata   = bus.cpu_rvalid ? hit_word : 32'd0;
  assign bus.cpu_ready   = ready_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.stat_hits   = hits_q;
  assign bus.stat_misses = misses_q;
  assign dbg_state_o     = state_q;

  // Line data: write-hit word update and refill install (contents need no reset).
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ((state_q == S_COMPARE) && hit && wren_q)
        data_q[hit_way][idx][{word_sel, 5'b0} +: 32] <= wdata_q;
      if ((state_q == S_REFILL_WAIT) && bus.mem_rvalid)
        data_q[victim_q][idx] <= bus.mem_rdata;
    end
  end

  // Controller FSM with registered outputs, metadata and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      first_q     <= 1'b0;
      wren_q      <= 1'b0;
      wdata_q     <= '0;
      la_q        <= '0;
      victim_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[w][s] <= AW'(w);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cpu_req) begin
            la_q    <= bus.cpu_addr[ADDR_W-1:2];
            wren_q  <= bus.cpu_wren;
            wdata_q <= bus.cpu_wdata;
            first_q <= 1'b1;
            ready_q <= 1'b0;
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          first_q <= 1'b0;
          if (hit) begin
            if (first_q) hits_q <= hits_q + 32'd1;
            if (wren_q) dirty_q[idx][hit_way] <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            if (first_q) misses_q <= misses_q + 32'd1;
            victim_q <= vic_way;
            if (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) begin
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= {tag_q[vic_way][idx], idx};
              mem_wdata_q <= data_q[vic_way][idx];
              state_q     <= S_WRITEBACK;
            end else begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= line_addr;
              state_q    <= S_REFILL_REQ;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.mem_wack) begin
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= line_addr;
            state_q    <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          mem_rd_q <= 1'b0;
          state_q  <= S_REFILL_WAIT;
        end
        S_REFILL_WAIT: begin
          if (bus.mem_rvalid) begin
            tag_q[victim_q][idx]   <= tag;
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            state_q                <= S_COMPARE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // True-LRU: touched way becomes youngest, younger ways age by one.
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == upd_way) age_q[w][idx] <= '0;
          else if (age_q[w][idx] < upd_age) age_q[w][idx] <= age_q[w][idx] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache with a line memory model
// (refill after 5 cycles, writeback acknowledged after 3 cycles).
module tb_assoc_wb_cache;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int LA_W   = 28;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;
  int         total = 0;
  int         bad   = 0;

  assoc_wb_cache_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .LA_W(LA_W)) bus ();

  assoc_wb_cache dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // memory model and bus monitor state
  int              rd_cnt = 0;
  logic [LA_W-1:0] rd_la = '0;
  int              wr_run = 0;
  int              rd_pulses = 0;
  int              wr_cycles = 0;
  int              wr_unstable = 0;
  int              rvalid_pulses = 0;
  logic            prev_wr = 1'b0;
  logic [LA_W-1:0] last_rd_addr = '0;
  logic [LA_W-1:0] last_wr_addr = '0;
  logic [LINE_W-1:0] last_wr_data = '0;

  function automatic logic [LINE_W-1:0] line_of(input logic [LA_W-1:0] la);
    logic [31:0] b;
    b = {la, 4'h0};
    return {b + 32'd12, b + 32'd8, b + 32'd4, b};
  endfunction

  // memory model: drives responses and records bus activity on falling edges
  always @(negedge clk) begin
    bus.mem_rvalid = 1'b0;
    bus.mem_wack   = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = line_of(rd_la);
      end
    end
    if (bus.mem_rd === 1'b1) begin
      rd_cnt       = 5;
      rd_la        = bus.mem_addr;
      last_rd_addr = bus.mem_addr;
      rd_pulses++;
    end
    if (bus.mem_wr === 1'b1) begin
      wr_cycles++;
      wr_run++;
      if (prev_wr && (bus.mem_addr !== last_wr_addr || bus.mem_wdata !== last_wr_data))
        wr_unstable++;
      last_wr_addr = bus.mem_addr;
      last_wr_data = bus.mem_wdata;
      if (wr_run == 3) begin
        bus.mem_wack = 1'b1;
        wr_run       = 0;
      end
    end else begin
      wr_run = 0;
    end
    prev_wr = bus.mem_wr;
    if (bus.cpu_rvalid === 1'b1) rvalid_pulses++;
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check(tag, {96'b0, obs}, {96'b0, exp});
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  // driver: issue one request; returns read data, cycles to completion, done flag
  task automatic cpu_access(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat, output logic ok);
    int n;
    n = 0;
    while (bus.cpu_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_wren  = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    lat = 1;
    ok  = 1'b0;
    rd  = 32'd0;
    while (lat < 100) begin
      if (!wr && bus.cpu_rvalid === 1'b1) begin
        rd = bus.cpu_rdata;
        ok = 1'b1;
        break;
      end
      if (wr && bus.cpu_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // read helper: checks completion and returned word, then steps to IDLE
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int          lat;
    logic        ok;
    cpu_access(addr, 1'b0, 32'd0, rd, lat, ok);
    chk1({tag, "_done"}, ok, 1'b1);
    chk32({tag, "_data"}, rd, exp);
    @(negedge clk);
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    int          lat;
    logic        ok;
    cpu_access(addr, 1'b1, wd, rd, lat, ok);
    chk1({tag, "_done"}, ok, 1'b1);
  endtask

  // directed sequence
  initial begin
    logic [31:0] rd;
    int          lat;
    logic        ok;
    int          r0, w0, v0, n;

    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_wren  = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_wack  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk1("rst_ready", bus.cpu_ready, 1'b1);
    chk1("rst_rvalid", bus.cpu_rvalid, 1'b0);
    chk32("rst_rdata", bus.cpu_rdata, 32'd0);
    chk1("rst_mem_rd", bus.mem_rd, 1'b0);
    chk1("rst_mem_wr", bus.mem_wr, 1'b0);
    chk32("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, '0);
    chk32("rst_hits", bus.stat_hits, 32'd0);
    chk32("rst_misses", bus.stat_misses, 32'd0);
    chk32("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // cold read miss
    r0 = rd_pulses;
    do_read("cold", 32'h0000_0040, 32'h0000_0040);
    chk32("cold_rd_pulses", rd_pulses - r0, 32'd1);
    chk32("cold_rd_addr", 32'(last_rd_addr), 32'h0000_0004);
    chk32("cold_misses", bus.stat_misses, 32'd1);
    chk32("cold_hits", bus.stat_hits, 32'd0);

    // read hit: rvalid one cycle after acceptance, ready two cycles after
    r0 = rd_pulses;
    cpu_access(32'h0000_0044, 1'b0, 32'd0, rd, lat, ok);
    chk1("hit_done", ok, 1'b1);
    chk32("hit_data", rd, 32'h0000_0044);
    chk32("hit_latency", lat, 32'd1);
    chk1("hit_busy", bus.cpu_ready, 1'b0);
    @(negedge clk);
    chk1("hit_ready_back", bus.cpu_ready, 1'b1);
    chk32("hit_no_rd", rd_pulses - r0, 32'd0);
    chk32("hit_hits", bus.stat_hits, 32'd1);

    // write hit then read back
    r0 = rd_pulses;
    w0 = wr_cycles;
    do_write("wh", 32'h0000_0048, 32'hDEAD_BEEF);
    do_read("wh_rd", 32'h0000_0048, 32'hDEAD_BEEF);
    chk32("wh_no_rd", rd_pulses - r0, 32'd0);
    chk32("wh_no_wr", wr_cycles - w0, 32'd0);
    chk32("wh_hits", bus.stat_hits, 32'd3);

    // LRU: fill way 1, touch way 0, new line evicts the clean way 1
    do_read("lru_fill", 32'h0000_1040, 32'h0000_1040);
    chk32("lru_fill_addr", 32'(last_rd_addr), 32'h0000_0104);
    do_read("lru_touch", 32'h0000_0040, 32'h0000_0040);
    w0 = wr_cycles;
    do_read("lru_evict", 32'h0000_2040, 32'h0000_2040);
    chk32("lru_no_wr", wr_cycles - w0, 32'd0);
    chk32("lru_rd_addr", 32'(last_rd_addr), 32'h0000_0204);
    r0 = rd_pulses;
    do_read("lru_reread", 32'h0000_0040, 32'h0000_0040);
    chk32("lru_reread_no_rd", rd_pulses - r0, 32'd0);
    chk32("lru_hits", bus.stat_hits, 32'd5);
    chk32("lru_misses", bus.stat_misses, 32'd3);

    // dirty eviction: touch 0x2040 so the dirty 0x0040 line is LRU
    do_read("de_touch", 32'h0000_2040, 32'h0000_2040);
    w0 = wr_cycles;
    v0 = wr_unstable;
    do_read("de_evict", 32'h0000_1040, 32'h0000_1040);
    chk32("de_wr_cycles", wr_cycles - w0, 32'd3);
    chk32("de_wr_stable", wr_unstable - v0, 32'd0);
    chk32("de_wr_addr", 32'(last_wr_addr), 32'h0000_0004);
    chk32("de_wr_word2", last_wr_data[95:64], 32'hDEAD_BEEF);
    check("de_wr_line", last_wr_data, {32'h0000_004C, 32'hDEAD_BEEF, 32'h0000_0044, 32'h0000_0040});
    chk32("de_rd_addr", 32'(last_rd_addr), 32'h0000_0104);
    chk1("de_wr_low", bus.mem_wr, 1'b0);
    chk32("de_hits", bus.stat_hits, 32'd6);
    chk32("de_misses", bus.stat_misses, 32'd4);

    // write miss: allocate, then the written word and a neighbour read back
    do_write("wm", 32'h0000_0054, 32'h1234_5678);
    do_read("wm_rd", 32'h0000_0054, 32'h1234_5678);
    do_read("wm_nb", 32'h0000_0058, 32'h0000_0058);
    chk32("wm_hits", bus.stat_hits, 32'd8);
    chk32("wm_misses", bus.stat_misses, 32'd5);

    // reset in the middle of a refill
    bus.cpu_req  = 1'b1;
    bus.cpu_wren = 1'b0;
    bus.cpu_addr = 32'h0000_0080;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (dbg_state !== 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk32("mr_reach_wait", 32'(dbg_state), 32'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk1("mr_ready", bus.cpu_ready, 1'b1);
    chk32("mr_state", 32'(dbg_state), 32'd0);
    chk32("mr_hits", bus.stat_hits, 32'd0);
    chk32("mr_misses", bus.stat_misses, 32'd0);
    v0 = rvalid_pulses;
    repeat (10) @(negedge clk);
    chk32("mr_no_rvalid", rvalid_pulses - v0, 32'd0);
    chk32("mr_idle", 32'(dbg_state), 32'd0);
    r0 = rd_pulses;
    do_read("mr_reread", 32'h0000_0080, 32'h0000_0080);
    chk32("mr_reread_rd", rd_pulses - r0, 32'd1);
    chk32("mr_reread_misses", bus.stat_misses, 32'd1);
    chk32("mr_reread_hits", bus.stat_hits, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
